// File: rtl/fp_mant_normalizer.sv
// Post-add mantissa normalizer: absorbs adder carry-out or left-shifts one bit
// per cycle until the hidden bit is set, adjusting the exponent alongside.
module fp_mant_normalizer #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_overflow,
  output logic              busy
);

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, busy_q, out_valid_q;

  // Next-state and datapath step; priority inside NORM is carry, zero, normalized, floor, shift.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
          carry_d = in_carry;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (carry_q) begin
          carry_d = 1'b0;
          state_d = DONE;
          // exp+1 reaching all-ones (or beyond) saturates to infinity
          if (exp_q >= EXP_MAX - EXP_W'(1)) begin
            mant_d = '0;
            exp_d  = EXP_MAX;
            ovf_d  = 1'b1;
          end else begin
            mant_d = {1'b1, mant_q[MANT_W-1:1]};
            exp_d  = exp_q + EXP_W'(1);
          end
        end else if (mant_q == '0) begin
          exp_d   = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (mant_q[MANT_W-1]) begin
          state_d = DONE;
        end else if (exp_q <= EXP_W'(1)) begin
          exp_d   = '0;
          state_d = DONE;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign out_sign     = sign_q;
  assign out_exp      = exp_q;
  assign out_mant     = mant_q;
  assign out_zero     = zero_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_fp_mant_normalizer.sv
// Directed bench for fp_mant_normalizer: carry, multi-shift, zero, overflow,
// subnormal floor, backpressure and mid-operation reset.
module tb_fp_mant_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign, in_carry;
  logic [7:0]  in_exp;
  logic [23:0] in_mant;
  logic        out_valid, out_ready, out_sign, out_zero, out_overflow, busy;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mant_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_mant(out_mant), .out_zero(out_zero),
    .out_overflow(out_overflow), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one input; returns once the accepting edge (E0) has passed.
  task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    checks++;
    if (!in_ready) begin errors++; $display("FAIL send_ready_timeout got %b exp 1", in_ready); end
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_carry = c;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after E0 until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL handshake_idle got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_carry = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({out_valid, busy, out_sign, out_zero, out_overflow} !== 5'b0 || out_exp !== 8'h00 || out_mant !== 24'h0) begin
      errors++; $display("FAIL reset_outputs got v=%b b=%b e=%h m=%h exp all zero", out_valid, busy, out_exp, out_mant);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release got ready=%b busy=%b exp ready=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_carry();
    int lat;
    send(1'b1, 8'h7F, 24'h000001, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL carry_latency got %0d exp 1", lat); end
    checks++;
    if (out_mant !== 24'h800000 || out_exp !== 8'h80 || out_sign !== 1'b1) begin
      errors++; $display("FAIL carry_result got m=%h e=%h s=%b exp m=800000 e=80 s=1", out_mant, out_exp, out_sign);
    end
    checks++;
    if (out_zero !== 1'b0 || out_overflow !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL carry_flags got z=%b o=%b r=%b exp 0 0 0", out_zero, out_overflow, in_ready);
    end
    handshake();
  endtask

  task automatic test_multi_shift();
    int lat;
    send(1'b0, 8'h90, 24'h000F00, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 13) begin errors++; $display("FAIL multi_latency got %0d exp 13", lat); end
    checks++;
    if (out_mant !== 24'hF00000 || out_exp !== 8'h84) begin
      errors++; $display("FAIL multi_result got m=%h e=%h exp m=f00000 e=84", out_mant, out_exp);
    end
    handshake();
  endtask

  task automatic test_zero();
    int lat;
    send(1'b0, 8'h55, 24'h000000, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 1 || out_zero !== 1'b1 || out_overflow !== 1'b0 || out_exp !== 8'h00 || out_mant !== 24'h0) begin
      errors++; $display("FAIL zero_result got lat=%0d z=%b o=%b e=%h m=%h exp lat=1 z=1 o=0 e=00 m=0", lat, out_zero, out_overflow, out_exp, out_mant);
    end
    handshake();
  endtask

  task automatic test_overflow();
    int lat;
    send(1'b0, 8'hFE, 24'h7FFFFF, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat !== 1 || out_overflow !== 1'b1 || out_zero !== 1'b0 || out_exp !== 8'hFF || out_mant !== 24'h0) begin
      errors++; $display("FAIL overflow_result got lat=%0d o=%b z=%b e=%h m=%h exp lat=1 o=1 z=0 e=ff m=0", lat, out_overflow, out_zero, out_exp, out_mant);
    end
    handshake();
    // carry with zero mantissa is an ordinary increment
    send(1'b0, 8'h10, 24'h000000, 1'b1);
    wait_valid(lat);
    checks++;
    if (out_mant !== 24'h800000 || out_exp !== 8'h11 || out_zero !== 1'b0 || out_overflow !== 1'b0) begin
      errors++; $display("FAIL carry_zero_mant got m=%h e=%h z=%b o=%b exp m=800000 e=11 z=0 o=0", out_mant, out_exp, out_zero, out_overflow);
    end
    handshake();
  endtask

  task automatic test_subnormal();
    int lat;
    send(1'b0, 8'h03, 24'h000010, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 3 || out_mant !== 24'h000040 || out_exp !== 8'h00 || out_zero !== 1'b0) begin
      errors++; $display("FAIL subnormal_result got lat=%0d m=%h e=%h z=%b exp lat=3 m=000040 e=00 z=0", lat, out_mant, out_exp, out_zero);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    send(1'b0, 8'h7F, 24'h000001, 1'b1);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_exp = 8'h22; in_mant = 24'h000003; in_carry = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mant !== 24'h800000 || out_exp !== 8'h80) begin
        errors++; $display("FAIL backpressure_hold cycle %0d got v=%b r=%b m=%h e=%h exp v=1 r=0 m=800000 e=80", i, out_valid, in_ready, out_mant, out_exp);
      end
    end
    in_valid = 1'b0;
    handshake();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL backpressure_idle got busy=%b exp 0", busy); end
    send(1'b1, 8'h10, 24'h800001, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 1 || out_mant !== 24'h800001 || out_exp !== 8'h10 || out_sign !== 1'b1) begin
      errors++; $display("FAIL backpressure_next got lat=%0d m=%h e=%h s=%b exp lat=1 m=800001 e=10 s=1", lat, out_mant, out_exp, out_sign);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    send(1'b1, 8'h90, 24'h000F00, 1'b0);
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1 || out_mant !== 24'h00F000 || out_exp !== 8'h8C) begin
      errors++; $display("FAIL midop_progress got b=%b m=%h e=%h exp b=1 m=00f000 e=8c", busy, out_mant, out_exp);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({out_valid, busy, out_sign, out_zero, out_overflow} !== 5'b0 || out_exp !== 8'h00 || out_mant !== 24'h0) begin
      errors++; $display("FAIL midop_reset got v=%b b=%b s=%b e=%h m=%h exp all zero", out_valid, busy, out_sign, out_exp, out_mant);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midop_release got ready=%b exp 1", in_ready); end
    send(1'b0, 8'h90, 24'h000F00, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 13 || out_mant !== 24'hF00000 || out_exp !== 8'h84 || out_sign !== 1'b0) begin
      errors++; $display("FAIL midop_rerun got lat=%0d m=%h e=%h s=%b exp lat=13 m=f00000 e=84 s=0", lat, out_mant, out_exp, out_sign);
    end
    handshake();
  endtask

  task automatic test_worst_case();
    int lat;
    send(1'b0, 8'h80, 24'h000001, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 24 || out_mant !== 24'h800000 || out_exp !== 8'h69) begin
      errors++; $display("FAIL worst_case got lat=%0d m=%h e=%h exp lat=24 m=800000 e=69", lat, out_mant, out_exp);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_carry();
    test_multi_shift();
    test_zero();
    test_overflow();
    test_subnormal();
    test_worst_case();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
